player_sprite_drawer: RTL and testbench

//  Downstream of the player movement stage. On each movement tick it samples the player's

---
 rtl/soccer_pkg.sv | 25 ++
 rtl/sprite_scan.sv | 37 +++
 rtl/player_sprite_drawer.sv | 168 ++++++++++++++++
 tb/tb_player_sprite_drawer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/soccer_pkg.sv
// Shared constants for the soccer game video path: screen geometry, palette,
// sprite size and the sprite drawer state encoding.
package soccer_pkg;

  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int PLAYER_SIZE = 5;

  localparam logic [2:0] COL_BG = 3'b010;
  localparam logic [2:0] COL_P1 = 3'b100;
  localparam logic [2:0] COL_P2 = 3'b001;

  localparam logic [1:0] DS_IDLE_ENC  = 2'd0;
  localparam logic [1:0] DS_ERASE_ENC = 2'd1;
  localparam logic [1:0] DS_DRAW_ENC  = 2'd2;
  localparam logic [1:0] DS_DONE_ENC  = 2'd3;

  typedef enum logic [1:0] {
    DS_IDLE  = DS_IDLE_ENC,
    DS_ERASE = DS_ERASE_ENC,
    DS_DRAW  = DS_DRAW_ENC,
    DS_DONE  = DS_DONE_ENC
  } draw_state_t;

endpackage

// File: rtl/sprite_scan.sv
// Raster scan counter for a square sprite: dx runs 0..SIZE-1 inside dy 0..SIZE-1.
// last flags the final pixel of the box; advancing past it wraps to (0,0).
module sprite_scan #(
  parameter int SIZE = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clr,
  input  logic       en,
  output logic [2:0] dx,
  output logic [2:0] dy,
  output logic       last
);

  localparam logic [2:0] MAX = 3'(SIZE - 1);

  assign last = (dx == MAX) && (dy == MAX);

  // Step the scan position; clr wins over en
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dx <= '0;
      dy <= '0;
    end else if (clr) begin
      dx <= '0;
      dy <= '0;
    end else if (en) begin
      if (dx == MAX) begin
        dx <= '0;
        dy <= (dy == MAX) ? 3'd0 : dy + 3'd1;
      end else begin
        dx <= dx + 3'd1;
      end
    end
  end

endmodule

// File: rtl/player_sprite_drawer.sv
// Redraws one player's square sprite on each movement tick: erases the old box
// with the pitch colour, then draws the new box, as a registered pixel stream.
module player_sprite_drawer
  import soccer_pkg::*;
#(
  parameter int                  SIZE      = PLAYER_SIZE,
  parameter int                  COLOUR_W  = 3,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = COLOUR_W'(COL_BG),
  parameter logic [COLOUR_W-1:0] P_COLOUR  = COLOUR_W'(COL_P1)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                frame_tick,
  input  logic [7:0]          xPos,
  input  logic [6:0]          yPos,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam logic [7:0] SCR_W = 8'(SCREEN_W);
  localparam logic [6:0] SCR_H = 7'(SCREEN_H);

  // A slot whose wrapped coordinate falls off the visible area is skipped
  // without stalling the scan, so redraw latency never depends on position.
  function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
    return (x < SCR_W) && (y < SCR_H);
  endfunction

  draw_state_t state, state_nxt;

  logic [7:0] old_x, new_x;
  logic [6:0] old_y, new_y;
  logic       drawn_valid;

  logic       scan_clr, scan_en, scan_last;
  logic [2:0] dx, dy;

  logic       start, moved;
  logic [7:0] base_x, sum_x;
  logic [6:0] base_y, sum_y;

  logic [7:0]          x_nxt;
  logic [6:0]          y_nxt;
  logic [COLOUR_W-1:0] col_nxt;
  logic                plot_nxt, busy_nxt, done_nxt;

  sprite_scan #(
    .SIZE (SIZE)
  ) u_scan (
    .clock  (clock),
    .resetn (resetn),
    .clr    (scan_clr),
    .en     (scan_en),
    .dx     (dx),
    .dy     (dy),
    .last   (scan_last)
  );

  assign start  = (state == DS_IDLE) && frame_tick;
  assign moved  = (xPos != old_x) || (yPos != old_y);
  assign base_x = (state == DS_ERASE) ? old_x : new_x;
  assign base_y = (state == DS_ERASE) ? old_y : new_y;
  assign sum_x  = base_x + {5'd0, dx};
  assign sum_y  = base_y + {4'd0, dy};

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= DS_IDLE;
    else         state <= state_nxt;
  end

  // Next state, scan control and next values of the registered outputs
  always_comb begin
    state_nxt = state;
    scan_clr  = 1'b0;
    scan_en   = 1'b0;
    x_nxt     = vga_x;
    y_nxt     = vga_y;
    col_nxt   = vga_colour;
    plot_nxt  = 1'b0;
    done_nxt  = 1'b0;
    busy_nxt  = (state != DS_IDLE);
    unique case (state)
      DS_IDLE: begin
        if (frame_tick) begin
          scan_clr = 1'b1;
          busy_nxt = 1'b1;
          if (!drawn_valid) state_nxt = DS_DRAW;
          else if (moved)   state_nxt = DS_ERASE;
          else              state_nxt = DS_DONE;
        end
      end
      DS_ERASE: begin
        scan_en  = 1'b1;
        x_nxt    = sum_x;
        y_nxt    = sum_y;
        col_nxt  = BG_COLOUR;
        plot_nxt = on_screen(sum_x, sum_y);
        if (scan_last) begin
          scan_clr  = 1'b1;
          state_nxt = DS_DRAW;
        end
      end
      DS_DRAW: begin
        scan_en  = 1'b1;
        x_nxt    = sum_x;
        y_nxt    = sum_y;
        col_nxt  = P_COLOUR;
        plot_nxt = on_screen(sum_x, sum_y);
        if (scan_last) begin
          scan_clr  = 1'b1;
          state_nxt = DS_DONE;
        end
      end
      DS_DONE: begin
        done_nxt  = 1'b1;
        state_nxt = DS_IDLE;
      end
      default: state_nxt = DS_IDLE;
    endcase
  end

  // Position bookkeeping: sample on an accepted tick, commit at completion.
  // In the no-move case new equals old, so committing in DONE is harmless.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      new_x       <= '0;
      new_y       <= '0;
      old_x       <= '0;
      old_y       <= '0;
      drawn_valid <= 1'b0;
    end else begin
      if (start) begin
        new_x <= xPos;
        new_y <= yPos;
      end
      if (state == DS_DONE) begin
        old_x       <= new_x;
        old_y       <= new_y;
        drawn_valid <= 1'b1;
      end
    end
  end

  // Registered pixel stream and status outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      vga_x      <= x_nxt;
      vga_y      <= y_nxt;
      vga_colour <= col_nxt;
      plot       <= plot_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_player_sprite_drawer.sv
// Bench for player_sprite_drawer: table of redraw requests plus hand sequences
// for a tick during a redraw and an asynchronous reset mid-erase.
module tb_player_sprite_drawer;

  localparam logic [2:0] BG = 3'b010;
  localparam logic [2:0] PC = 3'b100;

  logic       clock, resetn, frame_tick;
  logic [7:0] xPos;
  logic [6:0] yPos;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot, busy, done;

  player_sprite_drawer dut (
    .clock      (clock),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .xPos       (xPos),
    .yPos       (yPos),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [7:0] x;
    logic [6:0] y;
    int         plots;
    int         lat;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [17:0] exp_q[$];
  logic [2:0]  fb[160][120];
  logic        m_valid;
  logic [7:0]  m_x;
  logic [6:0]  m_y;
  vec_t        vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic push_box(input logic [7:0] ox, input logic [6:0] oy, input logic [2:0] col);
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < 5; i++) begin
        logic [7:0] px;
        logic [6:0] py;
        px = ox + 8'(i);
        py = oy + 7'(j);
        if (px < 8'd160 && py < 7'd120) exp_q.push_back({px, py, col});
      end
    end
  endtask

  task automatic model_push(input logic [7:0] x, input logic [6:0] y);
    if (!m_valid) begin
      push_box(x, y, PC);
    end else if (x != m_x || y != m_y) begin
      push_box(m_x, m_y, BG);
      push_box(x, y, PC);
    end
    m_valid = 1'b1;
    m_x     = x;
    m_y     = y;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 160; i++)
      for (int j = 0; j < 120; j++)
        fb[i][j] = BG;
  endtask

  task automatic fb_check(input string name, input logic [7:0] x, input logic [6:0] y);
    int bad;
    bad = 0;
    for (int i = 0; i < 160; i++) begin
      for (int j = 0; j < 120; j++) begin
        logic [7:0] ddx;
        logic [6:0] ddy;
        logic [2:0] want;
        ddx  = 8'(i) - x;
        ddy  = 7'(j) - y;
        want = (ddx < 8'd5 && ddy < 7'd5) ? PC : BG;
        if (fb[i][j] !== want) bad++;
      end
    end
    check({name, "_framebuffer_bad_pixels"}, bad, 0);
  endtask

  task automatic reset_dut();
    @(negedge clock);
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    model_reset();
    resetn = 1'b1;
  endtask

  // Issue one tick and watch a fixed 61-cycle window after the sampling edge.
  task automatic do_tick(input string name, input logic [7:0] x, input logic [6:0] y,
                         input int exp_plots, input int exp_lat, input int extra_at);
    int plots, done_cnt, done_at, busy_cnt;
    plots = 0; done_cnt = 0; done_at = -1; busy_cnt = 0;
    model_push(x, y);
    @(negedge clock);
    xPos       = x;
    yPos       = y;
    frame_tick = 1'b1;
    for (int k = 0; k <= 60; k++) begin
      @(posedge clock);
      #1;
      frame_tick = (k + 1 == extra_at);
      if (k + 1 == extra_at) begin
        xPos = x + 8'd10;
        yPos = y + 7'd10;
      end
      if (plot) begin
        plots++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s_pixel: got unexpected plot x=%0d y=%0d c=%0d, expected none",
                   name, vga_x, vga_y, vga_colour);
        end else begin
          check({name, "_pixel"}, {vga_x, vga_y, vga_colour}, exp_q.pop_front());
        end
        if (vga_x < 8'd160 && vga_y < 7'd120) fb[vga_x][vga_y] = vga_colour;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (busy) busy_cnt++;
    end
    check({name, "_plot_count"}, plots, exp_plots);
    check({name, "_done_latency"}, done_at, exp_lat);
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_busy_cycles"}, busy_cnt, exp_lat + 1);
    check({name, "_pixels_left"}, exp_q.size(), 0);
    fb_check(name, x, y);
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'd40,  7'd56,  25, 26};
    vecs[1] = '{1'b0, 8'd41,  7'd56,  50, 51};
    vecs[2] = '{1'b0, 8'd41,  7'd56,   0,  1};
    vecs[3] = '{1'b1, 8'd158, 7'd118,  4, 26};
    vecs[4] = '{1'b0, 8'd100, 7'd50,  29, 51};
    vecs[5] = '{1'b0, 8'd100, 7'd50,   0,  1};
    vecs[6] = '{1'b0, 8'd155, 7'd115, 50, 51};

    resetn     = 1'b0;
    frame_tick = 1'b0;
    xPos       = '0;
    yPos       = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {vga_x, vga_y, vga_colour, plot, busy, done}, '0);
    @(negedge clock);
    resetn = 1'b1;

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].rst) reset_dut();
      do_tick($sformatf("vec%0d", v), vecs[v].x, vecs[v].y, vecs[v].plots, vecs[v].lat, -1);
    end

    // Tick and position change ten edges into a move must be ignored
    do_tick("busy_tick", 8'd60, 7'd60, 50, 51, 10);

    // Asynchronous reset in the middle of an erase
    @(negedge clock);
    xPos       = 8'd20;
    yPos       = 7'd20;
    frame_tick = 1'b1;
    @(posedge clock);
    #1;
    frame_tick = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("mid_erase_plot", {plot, vga_colour}, {1'b1, BG});
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_outputs", {vga_x, vga_y, vga_colour, plot, busy, done}, '0);
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
    do_tick("after_reset", 8'd20, 7'd20, 25, 26, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
